// File: rtl/t05_sram_pkg.sv
// Shared types and constants for the SRAM request port responder and its requester.
package t05_sram_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } bus_state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3300_0000;

  // Region offsets the requester already places its tables at.
  localparam logic [31:0] REGION_HIST     = 32'd0;
  localparam logic [31:0] REGION_FLV      = 32'd0;
  localparam logic [31:0] REGION_HTREE    = 32'd1024;
  localparam logic [31:0] REGION_CODEBOOK = 32'd2048;

endpackage

// File: rtl/t05_sram_bus_responder.sv
// Turns each rising-edge request on the SRAM port into one Wishbone B4 classic
// cycle, returning read data and a timeout flag to the requester.
module t05_sram_bus_responder
  import t05_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_en,
  input  logic        wr_en,
  input  logic [3:0]  select,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  bus_state_t  state;
  logic        req;
  logic        req_prev;
  logic        accept;
  logic        expire;
  logic [7:0]  tmo_cnt;
  logic [31:0] word_adr;

  assign req      = r_en | wr_en;
  assign accept   = (state == IDLE) && req && !req_prev;
  assign expire   = (tmo_cnt == TMO_LAST);
  // Byte offset bits are dropped; the sum wraps at 32 bits.
  assign word_adr = BASE_ADDR + (addr & 32'hFFFF_FFFC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_prev <= 1'b0;
      tmo_cnt  <= 8'd0;
      data_o   <= 32'd0;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 4'd0;
      wb_adr_o <= 32'd0;
      wb_dat_o <= 32'd0;
    end else begin
      req_prev <= req;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= BUS;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            busy_o   <= 1'b1;
            // Write takes priority when both enables rise together.
            wb_we_o  <= wr_en;
            wb_sel_o <= select;
            wb_dat_o <= data_i;
            wb_adr_o <= word_adr;
            err_o    <= 1'b0;
            tmo_cnt  <= 8'd0;
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            busy_o   <= 1'b0;
            if (!wb_we_o) begin
              data_o <= wb_dat_i;
            end
          end else if (expire) begin
            state    <= IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            busy_o   <= 1'b0;
            err_o    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
      endcase
    end
  end

endmodule
